// File: rtl/cpu_pkg.sv
// Shared pipeline types for operand forwarding and hazard control.
// Shadow-slot layout, forward-select encodings and hazard FSM states.
package cpu_pkg;

  localparam int SLOT_RA_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RA_W-1:0] rd;
    logic                 reg_wen;
    logic                 is_load;
    logic                 csr_reg_en;
  } slot_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // x0 is hardwired, so a slot targeting it never produces a value
  function automatic logic writes(
    slot_t                s,
    logic [SLOT_RA_W-1:0] r
  );
    return s.valid & s.reg_wen &
           (s.rd == r) & (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward source select.
// The nearer producer (EX, landing in MEM) wins over MEM.
module fwd_select
  import cpu_pkg::*;
(
  input  logic                 use_rs,
  input  logic [SLOT_RA_W-1:0] rs,
  input  slot_t                ex_slot,
  input  slot_t                mem_slot,
  output logic [1:0]           sel
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = use_rs & writes(ex_slot, rs);
  assign hit_mem = use_rs & writes(mem_slot, rs);

  always_comb begin
    sel = FWD_NONE;
    priority case (1'b1)
      hit_ex:  sel = FWD_MEM;
      hit_mem: sel = FWD_WB;
      default: sel = FWD_NONE;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and load-use hazard control.
// Shadows EX/MEM/WB destinations and registers forward selects.
module fwd_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_wen,
  input  logic             id_is_load,
  input  logic             id_csr_reg_en,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             mem_csr_reg_en,
  output logic             wb_csr_reg_en,
  output logic [CNT_W-1:0] lu_stall_count
);

  slot_t      ex_q;
  slot_t      mem_q;
  slot_t      wb_q;
  slot_t      id_slot;
  state_t     state_q;
  state_t     state_d;
  logic       lu;
  logic [1:0] nxt_a;
  logic [1:0] nxt_b;

  assign id_slot = '{
    valid:      id_valid,
    rd:         id_rd,
    reg_wen:    id_reg_wen,
    is_load:    id_is_load,
    csr_reg_en: id_csr_reg_en
  };

  fwd_select u_sel_a (
    .use_rs   (id_use_rs1),
    .rs       (id_rs1),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (nxt_a)
  );

  fwd_select u_sel_b (
    .use_rs   (id_use_rs2),
    .rs       (id_rs2),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (nxt_b)
  );

  always_comb begin
    lu      = 1'b0;
    state_d = RUN;
    unique case (state_q)
      RUN: begin
        lu = id_valid & ex_q.is_load &
             ((id_use_rs1 & writes(ex_q, id_rs1)) |
              (id_use_rs2 & writes(ex_q, id_rs2)));
        state_d = (lu & ~flush) ? STALL : RUN;
      end
      STALL: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign stall_if_id = lu & ~flush;
  assign bubble_ex   = (lu | flush) & ~ext_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      state_q        <= RUN;
      forwardA       <= FWD_NONE;
      forwardB       <= FWD_NONE;
      mem_csr_reg_en <= 1'b0;
      wb_csr_reg_en  <= 1'b0;
      lu_stall_count <= '0;
    end else if (!ext_stall) begin
      mem_q          <= ex_q;
      wb_q           <= mem_q;
      mem_csr_reg_en <= ex_q.valid & ex_q.csr_reg_en;
      wb_csr_reg_en  <= mem_q.valid & mem_q.csr_reg_en;
      state_q        <= state_d;
      if (flush || lu) begin
        ex_q     <= '0;
        forwardA <= FWD_NONE;
        forwardB <= FWD_NONE;
      end else begin
        ex_q     <= id_slot;
        forwardA <= nxt_a;
        forwardB <= nxt_b;
      end
      // a flushed load-use never issues, so it is not counted
      if (lu && !flush && lu_stall_count != '1)
        lu_stall_count <= lu_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl.
// Vector table plus freeze and async-reset sequences.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_wen;
  logic        id_is_load;
  logic        id_csr_reg_en;
  logic        flush;
  logic        ext_stall;
  logic        stall_if_id;
  logic        bubble_ex;
  logic [1:0]  forwardA;
  logic [1:0]  forwardB;
  logic        mem_csr_reg_en;
  logic        wb_csr_reg_en;
  logic [31:0] lu_stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_reg_wen     (id_reg_wen),
    .id_is_load     (id_is_load),
    .id_csr_reg_en  (id_csr_reg_en),
    .flush          (flush),
    .ext_stall      (ext_stall),
    .stall_if_id    (stall_if_id),
    .bubble_ex      (bubble_ex),
    .forwardA       (forwardA),
    .forwardB       (forwardB),
    .mem_csr_reg_en (mem_csr_reg_en),
    .wb_csr_reg_en  (wb_csr_reg_en),
    .lu_stall_count (lu_stall_count)
  );

  typedef struct {
    int v, rs1, rs2, u1, u2, rd, wen, ld, csr, fl, es;
    int st, bub, fa, fb, mc, wc, cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    id_valid      = 1'(x.v);
    id_rs1        = 5'(x.rs1);
    id_rs2        = 5'(x.rs2);
    id_use_rs1    = 1'(x.u1);
    id_use_rs2    = 1'(x.u2);
    id_rd         = 5'(x.rd);
    id_reg_wen    = 1'(x.wen);
    id_is_load    = 1'(x.ld);
    id_csr_reg_en = 1'(x.csr);
    flush         = 1'(x.fl);
    ext_stall     = 1'(x.es);
  endtask

  task automatic step(input vec_t x, input string tag);
    @(negedge clk);
    drive(x);
    #1;
    chk({tag, ".stall"}, int'(stall_if_id), x.st);
    chk({tag, ".bubble"}, int'(bubble_ex), x.bub);
    @(posedge clk);
    #1;
    chk({tag, ".fwdA"}, int'(forwardA), x.fa);
    chk({tag, ".fwdB"}, int'(forwardB), x.fb);
    chk({tag, ".memcsr"}, int'(mem_csr_reg_en), x.mc);
    chk({tag, ".wbcsr"}, int'(wb_csr_reg_en), x.wc);
    chk({tag, ".cnt"}, int'(lu_stall_count), x.cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, int'(stall_if_id), 0);
    chk({tag, ".bubble"}, int'(bubble_ex), 0);
    chk({tag, ".fwdA"}, int'(forwardA), 0);
    chk({tag, ".fwdB"}, int'(forwardB), 0);
    chk({tag, ".memcsr"}, int'(mem_csr_reg_en), 0);
    chk({tag, ".wbcsr"}, int'(wb_csr_reg_en), 0);
    chk({tag, ".cnt"}, int'(lu_stall_count), 0);
  endtask

  initial begin
    vec_t nop;
    vec_t x;
    nop = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
    //       v rs1 rs2 u1 u2 rd wen ld csr fl es | st bub fa fb mc wc cnt
    tbl[0]  = '{1,1,2,1,1,5,1,0,0,0,0,   0,0,0,0,0,0,0};
    tbl[1]  = '{1,5,6,1,1,8,1,0,0,0,0,   0,0,2,0,0,0,0};
    tbl[2]  = nop;
    tbl[3]  = '{1,1,2,1,1,7,1,0,0,0,0,   0,0,0,0,0,0,0};
    tbl[4]  = nop;
    tbl[5]  = '{1,9,7,1,1,10,1,0,0,0,0,  0,0,0,1,0,0,0};
    tbl[6]  = '{1,1,2,1,1,7,1,0,0,0,0,   0,0,0,0,0,0,0};
    tbl[7]  = '{1,7,0,1,0,7,1,0,0,0,0,   0,0,2,0,0,0,0};
    tbl[8]  = '{1,3,7,1,1,11,1,0,0,0,0,  0,0,0,2,0,0,0};
    tbl[9]  = '{1,1,2,1,1,0,1,0,0,0,0,   0,0,0,0,0,0,0};
    tbl[10] = '{1,0,0,1,1,12,1,0,0,0,0,  0,0,0,0,0,0,0};
    tbl[11] = '{1,1,12,1,0,13,1,0,0,0,0, 0,0,0,0,0,0,0};
    tbl[12] = '{1,2,0,1,0,3,1,1,0,0,0,   0,0,0,0,0,0,0};
    tbl[13] = '{1,3,4,1,1,14,1,0,0,0,0,  1,1,0,0,0,0,1};
    tbl[14] = '{1,3,4,1,1,14,1,0,0,0,0,  0,0,1,0,0,0,1};
    tbl[15] = '{1,2,0,1,0,3,1,1,0,0,0,   0,0,0,0,0,0,1};
    tbl[16] = '{1,3,4,1,1,15,1,0,0,1,0,  0,1,0,0,0,0,1};
    tbl[17] = '{1,0,0,0,0,20,1,0,1,0,0,  0,0,0,0,0,0,1};
    tbl[18] = '{0,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,1,0,1};
    tbl[19] = '{1,20,0,1,0,21,1,0,0,0,0, 0,0,1,0,0,1,1};

    drive(nop);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      step(tbl[i], $sformatf("row%0d", i));

    // freeze three cycles: registered outputs hold
    x = '{1,21,0,1,0,22,1,0,0,0,1, 0,0,1,0,0,1,1};
    for (int i = 0; i < 3; i++)
      step(x, $sformatf("freeze%0d", i));
    x.es = 0; x.fa = 2; x.wc = 0;
    step(x, "thaw");

    step('{1,1,0,1,0,6,1,1,0,0,0, 0,0,0,0,0,0,1}, "lw6");
    step('{1,6,0,1,0,23,1,0,0,0,0, 1,1,0,0,0,0,2}, "lu6");

    // now in STALL: no new stall, then async reset mid-cycle
    @(negedge clk);
    drive('{1,6,0,1,0,23,1,0,0,0,0, 0,0,0,0,0,0,0});
    #1;
    chk("stallst.stall", int'(stall_if_id), 0);
    chk("stallst.bubble", int'(bubble_ex), 0);
    rst_n = 1'b0;
    #1;
    chk_zero("areset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step('{1,6,0,1,0,23,1,0,0,0,0, 0,0,0,0,0,0,0}, "reissue");
    step('{1,1,0,1,0,6,1,1,0,0,0,  0,0,0,0,0,0,0}, "lw6b");
    step('{1,6,0,1,0,24,1,0,0,0,0, 1,1,0,0,0,0,1}, "lu6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Producer side of the EX-stage operand-forwarding interface: generates the forwardA/forwardB selects and the MEM/WB CSR-forward enables consumed by the ALU operand muxes.
- Tracks destination metadata of in-flight instructions in shadow EX/MEM/WB registers.
- Detects load-use hazards and inserts a one-cycle bubble.
- Honours branch flush and external pipeline freeze.
- Sits beside the ID/EX pipeline register; all forward outputs are registered so they are valid during the consumer's EX cycle.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 32, width of the load-use stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  RA_W  source register 1 of ID instruction.
- id_rs2  in  RA_W  source register 2 of ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1 (ASel==0 path).
- id_use_rs2  in  1  ID instruction reads rs2 (BSel==0 or store data).
- id_rd  in  RA_W  destination of ID instruction.
- id_reg_wen  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_csr_reg_en  in  1  ID instruction writes rd from CSR read.
- flush  in  1  EX-resolved redirect; kills ID instruction.
- ext_stall  in  1  global freeze (e.g. dmem busy).
- stall_if_id  out  1  hold PC and IF/ID register this cycle.
- bubble_ex  out  1  load NOP into ID/EX at next edge.
- forwardA  out  2  10 = MEM result, 01 = WB result, 00 = register file.
- forwardB  out  2  same encoding for operand B.
- mem_csr_reg_en  out  1  MEM-stage instruction's rd comes from CSR.
- wb_csr_reg_en  out  1  WB-stage instruction's rd comes from CSR.
- lu_stall_count  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (async, rst_n=0):
  - all shadow valid bits 0, state RUN.
  - forwardA/B=00; mem/wb_csr_reg_en=0; lu_stall_count=0.
  - stall_if_id=0; bubble_ex=0.
- Shadow slots ex_, mem_, wb_ each hold {valid, rd, reg_wen, is_load, csr_reg_en}.
- A slot "writes r" iff valid & reg_wen & rd==r & rd!=0. x0 never forwards.
- Combinational hazard (RUN only):
  - lu = id_valid & ex_.is_load & ((id_use_rs1 & ex_ writes id_rs1) | (id_use_rs2 & ex_ writes id_rs2)).
  - stall_if_id = lu & ~flush.
  - bubble_ex = (lu | flush) & ~ext_stall.
- Next-forward per operand:
  - 10 if ex_ writes rs (producer will be in MEM).
  - else 01 if mem_ writes rs (producer will be in WB).
  - else 00.
  - Unused operand gives 00. MEM beats WB when both match.
- Clock edge, priority ext_stall > flush > lu > normal:
  - ext_stall: every register holds, including forward outputs and counter.
  - flush: ex_ <= bubble; mem_ <= ex_; wb_ <= mem_; forwardA/B <= 00; state stays RUN.
  - lu: ex_ <= bubble; mem_ <= ex_; wb_ <= mem_; forwardA/B <= 00; state <= STALL; counter +1, saturating at all-ones.
  - normal: ex_ <= ID fields (valid=id_valid); mem_ <= ex_; wb_ <= mem_; forwardA/B <= next-forward.
- mem_csr_reg_en <= ex_.valid & ex_.csr_reg_en (registered with the shift). wb_csr_reg_en likewise from mem_.
- FSM:
  - RUN: transitions to STALL on lu.
  - STALL: returns to RUN on the next non-frozen edge.
  - In STALL, lu is forced 0; the load is then in MEM and the dependent gets 01 from WB (WBdmem) on issue.
- Producer in WB while consumer in ID is not forwarded. The register file is write-first.
- Reset mid-stall returns to RUN with empty shadows. The pending ID instruction re-issues cleanly.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Packed struct typedef for a shadow slot.
  - FSM state enum {RUN, STALL}.
- One natural sub-module: fwd_select, the combinational per-operand priority compare, instantiated twice.
- Shift registers, FSM and counter stay in the top module.

Test Plan:
- Back-to-back dependency: issue add x5 (rd=5, wen), then sub rs1=5 → forwardA=10 during sub's EX, forwardB=00, no stall.
- Distance-2 dependency: add x7, nop, or rs2=7 → forwardB=01. Add x7, add x7, use x7 → forwardB=10 (MEM wins).
- Load-use: lw x3, then add rs1=3 → stall_if_id=1 and bubble_ex=1 for exactly one cycle. Next cycle forwardA=01. lu_stall_count 0→1.
- x0 and unused operands: add x0 then use rs1=0 → forwardA=00. Same rs2 match with id_use_rs2=0 → forwardB=00.
- Flush during load-use: lw x3, add rs1=3 with flush=1 same cycle → stall_if_id=0, bubble_ex=1, counter unchanged, forwards 00.
- ext_stall and reset: hold ext_stall 3 cycles mid-sequence → all outputs frozen, then resume with correct forwards. Assert rst_n=0 while in STALL → all outputs 0 immediately (async), state RUN.
